// File: rtl/ltl_nfa_engine.sv
// rtl/ltl_nfa_engine.sv - runtime-programmable homogeneous NFA trace monitor
// Match bitmaps, edges and start/report flags are loaded through the cfg port while run=0.
module ltl_nfa_engine #(
    parameter int N_STATES = 9,
    parameter int SYM_W    = 8,
    parameter int CNT_W    = 16,
    localparam int IDX_W   = (N_STATES > 1) ? $clog2(N_STATES) : 1,
    localparam int WORD_W  = (SYM_W > 6) ? SYM_W - 5 : 1,
    localparam int NSYM    = 1 << SYM_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic                clear,
    input  logic                sym_valid,
    output logic                sym_ready,
    input  logic [SYM_W-1:0]    sym,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_type,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [WORD_W-1:0]   cfg_word,
    input  logic [31:0]         cfg_data,
    output logic                cfg_err,
    output logic [N_STATES-1:0] active,
    output logic                rpt_valid,
    output logic [N_STATES-1:0] rpt_vec,
    output logic [N_STATES-1:0] rpt_sticky,
    output logic [CNT_W-1:0]    rpt_count
);

    logic [NSYM-1:0]     match_q [N_STATES];
    logic [NSYM-1:0]     match_d [N_STATES];
    logic [N_STATES-1:0] edge_q  [N_STATES];
    logic [N_STATES-1:0] edge_d  [N_STATES];
    logic [N_STATES-1:0] sod_q, sod_d, all_q, all_d, rmask_q, rmask_d;

    logic [N_STATES-1:0] active_q, active_d;
    logic [N_STATES-1:0] rpt_vec_q, rpt_vec_d;
    logic [N_STATES-1:0] rpt_sticky_q, rpt_sticky_d;
    logic [CNT_W-1:0]    rpt_count_q, rpt_count_d;
    logic                first_q, first_d;
    logic                rpt_valid_q, rpt_valid_d;
    logic                cfg_err_q, cfg_err_d;

    logic                accept;
    logic                cfg_bad;
    logic [N_STATES-1:0] act_next;
    logic [N_STATES-1:0] hit_vec;

    assign sym_ready  = run & ~clear;
    assign accept     = sym_valid & sym_ready;
    assign cfg_err    = cfg_err_q;
    assign active     = active_q;
    assign rpt_valid  = rpt_valid_q;
    assign rpt_vec    = rpt_vec_q;
    assign rpt_sticky = rpt_sticky_q;
    assign rpt_count  = rpt_count_q;

    // Configuration port: a rejected write leaves every table untouched.
    always_comb begin
        match_d   = match_q;
        edge_d    = edge_q;
        sod_d     = sod_q;
        all_d     = all_q;
        rmask_d   = rmask_q;
        cfg_bad   = run | (int'(cfg_idx) >= N_STATES) | (cfg_type == 2'd3);
        cfg_err_d = cfg_we & cfg_bad;
        if (cfg_we && !cfg_bad) begin
            for (int i = 0; i < N_STATES; i++) begin
                if (int'(cfg_idx) == i) begin
                    case (cfg_type)
                        2'd0: begin
                            for (int b = 0; b < NSYM; b++) begin
                                if (NSYM <= 32 || (b / 32) == int'(cfg_word)) begin
                                    match_d[i][b] = cfg_data[b % 32];
                                end
                            end
                        end
                        2'd1: edge_d[i] = cfg_data[N_STATES-1:0];
                        2'd2: begin
                            sod_d[i]   = cfg_data[0];
                            all_d[i]   = cfg_data[1];
                            rmask_d[i] = cfg_data[2];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_STATES; i++) begin
            act_next[i] = match_q[i][sym] &
                          (all_q[i] | (sod_q[i] & first_q) | (|(active_q & edge_q[i])));
        end
        hit_vec = act_next & rmask_q;
    end

    // Clear takes priority over an offered symbol; sym_ready is low anyway.
    always_comb begin
        active_d     = active_q;
        first_d      = first_q;
        rpt_valid_d  = 1'b0;
        rpt_vec_d    = rpt_vec_q;
        rpt_sticky_d = rpt_sticky_q;
        rpt_count_d  = rpt_count_q;
        if (clear) begin
            active_d     = '0;
            first_d      = 1'b1;
            rpt_vec_d    = '0;
            rpt_sticky_d = '0;
            rpt_count_d  = '0;
        end else if (accept) begin
            active_d     = act_next;
            first_d      = 1'b0;
            rpt_vec_d    = hit_vec;
            rpt_valid_d  = |hit_vec;
            rpt_sticky_d = rpt_sticky_q | hit_vec;
            if ((|hit_vec) && (rpt_count_q != {CNT_W{1'b1}})) begin
                rpt_count_d = rpt_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_STATES; i++) begin
                match_q[i] <= '0;
                edge_q[i]  <= '0;
            end
            sod_q        <= '0;
            all_q        <= '0;
            rmask_q      <= '0;
            active_q     <= '0;
            first_q      <= 1'b1;
            rpt_valid_q  <= 1'b0;
            rpt_vec_q    <= '0;
            rpt_sticky_q <= '0;
            rpt_count_q  <= '0;
            cfg_err_q    <= 1'b0;
        end else begin
            match_q      <= match_d;
            edge_q       <= edge_d;
            sod_q        <= sod_d;
            all_q        <= all_d;
            rmask_q      <= rmask_d;
            active_q     <= active_d;
            first_q      <= first_d;
            rpt_valid_q  <= rpt_valid_d;
            rpt_vec_q    <= rpt_vec_d;
            rpt_sticky_q <= rpt_sticky_d;
            rpt_count_q  <= rpt_count_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_ltl_nfa_engine.sv
// tb/tb_ltl_nfa_engine.sv - directed self-checking bench for ltl_nfa_engine
// Covers a default 9-state/8-bit instance and a 32-state/4-bit/2-bit-counter instance.
module tb_ltl_nfa_engine;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;

    logic        run = 1'b0, sym_valid = 1'b0, sym_ready, cfg_we = 1'b0, cfg_err;
    logic [7:0]  sym = '0;
    logic [1:0]  cfg_type = '0;
    logic [3:0]  cfg_idx = '0;
    logic [2:0]  cfg_word = '0;
    logic [31:0] cfg_data = '0;
    logic [8:0]  active, rpt_vec, rpt_sticky;
    logic        rpt_valid;
    logic [15:0] rpt_count;

    logic        run2 = 1'b0, sym_valid2 = 1'b0, sym_ready2, cfg_we2 = 1'b0, cfg_err2;
    logic [3:0]  sym2 = '0;
    logic [1:0]  cfg_type2 = '0;
    logic [4:0]  cfg_idx2 = '0;
    logic [0:0]  cfg_word2 = '0;
    logic [31:0] cfg_data2 = '0;
    logic [31:0] active2, rpt_vec2, rpt_sticky2;
    logic        rpt_valid2;
    logic [1:0]  rpt_count2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ltl_nfa_engine #(.N_STATES(9), .SYM_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .clear(clear),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym(sym),
        .cfg_we(cfg_we), .cfg_type(cfg_type), .cfg_idx(cfg_idx), .cfg_word(cfg_word),
        .cfg_data(cfg_data), .cfg_err(cfg_err), .active(active), .rpt_valid(rpt_valid),
        .rpt_vec(rpt_vec), .rpt_sticky(rpt_sticky), .rpt_count(rpt_count)
    );

    ltl_nfa_engine #(.N_STATES(32), .SYM_W(4), .CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .run(run2), .clear(clear),
        .sym_valid(sym_valid2), .sym_ready(sym_ready2), .sym(sym2),
        .cfg_we(cfg_we2), .cfg_type(cfg_type2), .cfg_idx(cfg_idx2), .cfg_word(cfg_word2),
        .cfg_data(cfg_data2), .cfg_err(cfg_err2), .active(active2), .rpt_valid(rpt_valid2),
        .rpt_vec(rpt_vec2), .rpt_sticky(rpt_sticky2), .rpt_count(rpt_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] t, input logic [3:0] idx, input logic [2:0] w,
                       input logic [31:0] d);
        cfg_we = 1'b1; cfg_type = t; cfg_idx = idx; cfg_word = w; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic cfg2(input logic [1:0] t, input logic [4:0] idx, input logic [31:0] d);
        cfg_we2 = 1'b1; cfg_type2 = t; cfg_idx2 = idx; cfg_word2 = '0; cfg_data2 = d;
        tick();
        cfg_we2 = 1'b0;
    endtask

    task automatic feed(input logic [7:0] s);
        sym_valid = 1'b1; sym = s;
        tick();
        sym_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        // Reset values, then an empty configuration activates nothing
        repeat (2) tick();
        chk("rst_active", active, 0);
        chk("rst_rpt_valid", rpt_valid, 0);
        chk("rst_rpt_vec", rpt_vec, 0);
        chk("rst_sticky", rpt_sticky, 0);
        chk("rst_count", rpt_count, 0);
        chk("rst_cfg_err", cfg_err, 0);
        reset_n = 1'b1;
        tick();
        run = 1'b1;
        feed(8'h03);
        chk("empty_cfg_active", active, 0);
        chk("empty_cfg_rpt", rpt_valid, 0);
        run = 1'b0;

        // Chain A->B->C
        cfg(2'd0, 4'd0, 3'd0, 32'h0000_00FF);
        cfg(2'd2, 4'd0, 3'd0, 32'h1);
        cfg(2'd0, 4'd1, 3'd0, 32'h0000_FF00);
        cfg(2'd1, 4'd1, 3'd0, 32'h1);
        for (int w = 0; w < 8; w++) cfg(2'd0, 4'd2, 3'(w), 32'hFFFF_FFFF);
        cfg(2'd1, 4'd2, 3'd0, 32'h6);
        cfg(2'd2, 4'd2, 3'd0, 32'h4);
        chk("cfg_ok_no_err", cfg_err, 0);
        do_clear();
        run = 1'b1;
        feed(8'h03);
        chk("chain_act0", active, 9'b001);
        chk("chain_rv0", rpt_valid, 0);
        feed(8'h0A);
        chk("chain_act1", active, 9'b010);
        chk("chain_rv1", rpt_valid, 0);
        feed(8'hFF);
        chk("chain_act2", active, 9'b100);
        chk("chain_rv2", rpt_valid, 1);
        chk("chain_vec2", rpt_vec, 9'b100);
        feed(8'h12);
        chk("chain_act3", active, 9'b100);
        chk("chain_rv3", rpt_valid, 1);
        chk("chain_count", rpt_count, 2);
        chk("chain_sticky", rpt_sticky, 9'b100);
        tick();
        chk("idle_rv", rpt_valid, 0);
        chk("idle_active_hold", active, 9'b100);
        chk("idle_count_hold", rpt_count, 2);

        // start_sod versus start_all
        do_clear();
        feed(8'h03);
        chk("sod_a", active, 9'b001);
        feed(8'h03);
        chk("sod_b", active, 9'b000);
        run = 1'b0;
        cfg(2'd2, 4'd0, 3'd0, 32'h2);
        do_clear();
        run = 1'b1;
        feed(8'h03);
        chk("all_a", active, 9'b001);
        feed(8'h03);
        chk("all_b", active, 9'b001);
        run = 1'b0;
        cfg(2'd2, 4'd0, 3'd0, 32'h1);
        do_clear();
        run = 1'b1;

        // Handshake stalls and run=0
        feed(8'h03);
        chk("hs_1", active, 9'b001);
        sym_valid = 1'b0; sym = 8'h0A;
        tick();
        chk("hs_stall", active, 9'b001);
        feed(8'h0A);
        chk("hs_3", active, 9'b010);
        run = 1'b0;
        #1;
        chk("run0_ready", sym_ready, 0);
        sym_valid = 1'b1; sym = 8'hFF;
        tick();
        chk("run0_hold", active, 9'b010);
        chk("run0_rv", rpt_valid, 0);
        sym_valid = 1'b0;
        run = 1'b1;
        feed(8'hFF);
        chk("pre_clear_act", active, 9'b100);
        chk("pre_clear_cnt", rpt_count, 1);

        // clear beats an offered symbol
        clear = 1'b1; sym_valid = 1'b1; sym = 8'hFF;
        #1;
        chk("clear_ready", sym_ready, 0);
        tick();
        chk("clear_active", active, 0);
        chk("clear_count", rpt_count, 0);
        chk("clear_sticky", rpt_sticky, 0);
        chk("clear_vec", rpt_vec, 0);
        clear = 1'b0; sym_valid = 1'b0;
        feed(8'h03);
        chk("clear_first", active, 9'b001);

        // Config rejection: run=1 (even with clear), bad index, reserved type
        clear = 1'b1;
        cfg(2'd0, 4'd0, 3'd0, 32'h0);
        chk("rej_run_err", cfg_err, 1);
        clear = 1'b0;
        tick();
        chk("rej_err_pulse", cfg_err, 0);
        feed(8'h03);
        chk("rej_match_kept", active, 9'b001);
        run = 1'b0;
        cfg(2'd0, 4'd9, 3'd0, 32'h0);
        chk("rej_idx_err", cfg_err, 1);
        cfg(2'd3, 4'd0, 3'd0, 32'h0);
        chk("rej_type3_err", cfg_err, 1);

        // Wide instance: self-looping all-match report state with saturating counter
        cfg2(2'd0, 5'd31, 32'h0000_FFFF);
        cfg2(2'd1, 5'd31, 32'h8000_0000);
        cfg2(2'd2, 5'd31, 32'h5);
        run2 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            sym_valid2 = 1'b1; sym2 = 4'(k * 3);
            tick();
            chk($sformatf("wide_rv_%0d", k), rpt_valid2, 1);
            chk($sformatf("wide_cnt_%0d", k), rpt_count2, (k < 3) ? k : 3);
            chk($sformatf("wide_act_%0d", k), active2, 32'h8000_0000);
        end
        sym_valid2 = 1'b0;
        chk("wide_sticky", rpt_sticky2, 32'h8000_0000);

        // Mid-stream async reset wipes everything, including configuration
        reset_n = 1'b0;
        #1;
        chk("mid_rst_active", active, 0);
        chk("mid_rst_active2", active2, 0);
        chk("mid_rst_count2", rpt_count2, 0);
        chk("mid_rst_sticky2", rpt_sticky2, 0);
        chk("mid_rst_cfg_err", cfg_err, 0);
        tick();
        reset_n = 1'b1;
        tick();
        run = 1'b1;
        feed(8'h03);
        chk("post_rst_empty", active, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ltl_nfa_engine.md
# ltl_nfa_engine

Runtime-programmable, parametrised automaton monitor for the RM monitor clusters. It evaluates an N-state homogeneous NFA (one state per symbol class, stride 1) over a stream of SYM_W-bit trace symbols. Per-state match bitmaps, transition matrix, start modes and report masks are loaded through a configuration port instead of being fixed at generation time. It adds a valid/ready symbol handshake, sticky report flags and a saturating report counter, and sits between the trace encoder and the monitor cluster's report aggregator.

## Interface
- N_STATES, 9, number of states; 1..32
- SYM_W, 8, symbol width; 2..8; each match bitmap holds 2^SYM_W bits
- CNT_W, 16, report counter width
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  **asynchronous, active-low reset**
- run  in  1  enables symbol consumption; configuration is accepted only while run=0
- clear  in  1  synchronous clear of run state: active, first-flag, sticky flags, counter
- sym_valid  in  1  symbol present
- sym_ready  out  1  `run & ~clear`
- sym  in  SYM_W  trace symbol
- cfg_we  in  1  configuration write strobe
- cfg_type  in  2  0 = match word, 1 = edge row, 2 = start/report flags
- cfg_idx  in  $clog2(N_STATES)  target state
- cfg_word  in  max(1, SYM_W-5)  32-bit word index within the match bitmap
- cfg_data  in  32  write data
- cfg_err  out  1  one-cycle pulse on a rejected write
- active  out  N_STATES  current active-state vector
- rpt_valid  out  1  one-cycle pulse: at least one reporting state became active
- rpt_vec  out  N_STATES  active & report_mask; registered together with rpt_valid
- rpt_sticky  out  N_STATES  OR-accumulation of rpt_vec
- rpt_count  out  CNT_W  saturating count of rpt_valid pulses

## Operation
- **Configuration registers:**
  - match[i]: 2^SYM_W bits per state.
  - edge_in[i]: N_STATES bits; bit j set means an edge from state j to state i.
  - start_sod[i]: start only on the first symbol.
  - start_all[i]: start on every symbol.
  - report_mask[i]
- **Configuration writes:**
  - Type 0 writes cfg_data into match[cfg_idx] bits [32·cfg_word +: 32]. When SYM_W<5, only the low 2^SYM_W bits are used.
  - Type 1 writes edge_in[cfg_idx] = cfg_data[N_STATES-1:0].
  - Type 2 writes start_sod = cfg_data[0], start_all = cfg_data[1], report_mask = cfg_data[2].
  - Type 3 is reserved.
- **Rejected writes:** a write is rejected, with cfg_err pulsed the next cycle and no register change, if run=1, cfg_idx ≥ N_STATES, or cfg_type=3.
- **Accept condition:** a symbol is accepted when `sym_valid & sym_ready`.
- **State update on accept**, for each state i:
  - `act_next[i] = match[i][sym] & (start_all[i] | (start_sod[i] & first) | |(active & edge_in[i]))`
  - active ← act_next
  - first ← 0
- **Report on accept:**
  - rpt_vec ← act_next & report_mask
  - rpt_valid ← |(act_next & report_mask)
  - rpt_sticky |= that vector
  - rpt_count increments on report and saturates at 2^CNT_W−1
- **No accept:** active, first, rpt_vec and rpt_sticky hold; rpt_valid=0.
- **clear=1:**
  - active=0, first=1, rpt_vec=0, rpt_valid=0, rpt_sticky=0, rpt_count=0.
  - No symbol is accepted that cycle, because sym_ready=0.
  - Configuration is retained.
- **run=0:** no symbol is accepted; state holds.

## Timing
- **Async reset (reset_n low):**
  - active=0, first=1, rpt_valid=0, rpt_vec=0, rpt_sticky=0, rpt_count=0, cfg_err=0.
  - All configuration registers are 0.
- **Reset deassertion:** registers release on the first clk edge after reset_n deasserts.
- **Latency:**
  - Symbol accepted at edge k: active, rpt_* and rpt_count are visible after edge k (1-cycle latency).
  - Back-to-back symbols are accepted every cycle.
- **Configuration latency:** a config write at edge k takes effect for symbols accepted at edge k+1 onward.
- **Simultaneous events:**
  - clear beats symbol.
  - A config write with run=1 is rejected even if clear=1.
- **Counter saturation:** at the maximum value rpt_count holds while rpt_valid still pulses.
- **Reset mid-stream:** asserting reset_n mid-stream wipes configuration; the automaton must be reprogrammed.

## Test plan
- **Reset values:** assert reset_n=0 mid-stream → all outputs 0 immediately; after release, a symbol with run=1 gives active=0 (empty configuration).
- **Chain A→B→C, SYM_W=8:**
  - Program: state0 matches 0x00–0x07 with start_sod; state1 matches 0x08–0x0F with edge from state0; state2 matches all symbols with edges from states 1 and 2, report enabled.
  - Stream 0x03, 0x0A, 0xFF, 0x12:
    - active = 001, 010, 100, 100
    - rpt_valid on cycles 3 and 4
    - rpt_count = 2
    - rpt_sticky = 100
- **start_sod vs start_all:**
  - Stream 0x03, 0x03 with start_sod only → active 001 then 000.
  - Same stream with start_all → 001, 001.
- **Handshake stalls:**
  - sym_valid toggled 1,0,1 → state advances only on cycles 1 and 3.
  - run=0 → sym_ready=0 and state holds.
- **clear and config rejection:**
  - clear with sym_valid=1 → active=0, count=0, symbol dropped; next symbol is treated as first (start_sod fires).
  - Config write with run=1 → cfg_err=1 for one cycle; match table unchanged.
  - cfg_idx=N_STATES → cfg_err=1.
- **Saturation and wide-N stress:**
  - CNT_W=2 with 5 reports → rpt_count=3.
  - N_STATES=32 with a self-looping all-match report state → rpt_valid every cycle.
